input_controller: RTL and testbench
===================================

// Module: input_controller
// PURPOSE
//  Conditions the four raw board buttons (btn_l/btn_r/btn_d/btn_u) into a
//  per-frame game command word for the chipinvaders game logic. Synchronises,
//  debounces and edge-detects each button, runs a fire auto-repeat FSM and
//  emits one command per frame_tick over a valid/ready handshake.
//  Sits between the top-level button pins and the game-state update logic.
// PARAMETERS
//  DEBOUNCE_CYCLES     250000  consecutive stable clk cycles before a debounced level changes (10 ms @ 25 MHz)
//  REPEAT_DELAY_FRAMES 20      frames fire must be held before the first auto-repeat
//  REPEAT_RATE_FRAMES  4       frames between subsequent auto-repeat fires
// PORTS
//  clk         in   1  pixel/system clock; single clock domain
//  rst_n       in   1  asynchronous active-low reset
//  btn_l       in   1  raw button, move left (asynchronous to clk)
//  btn_r       in   1  raw button, move right
//  btn_d       in   1  raw button, fire
//  btn_u       in   1  raw button, pause toggle
//  frame_tick  in   1  one-cycle pulse per frame (start of vertical blank)
//  cmd_valid   out  1  command word pending
//  cmd_ready   in   1  consumer accepts the command when cmd_valid && cmd_ready
//  cmd         out  4  {pause, fire, move_r, move_l}
//  btn_level   out  4  debounced levels {u, d, r, l}, for debug LEDs
// BEHAVIOUR
//  - Reset: all outputs 0; sync flops, debounce counters, repeat FSM and pending accumulators cleared.
//  - Sync: 2-flop synchroniser per button; 2 cycles of latency before the debouncer sees an input.
//  - Debounce: per button, counter of width $clog2(DEBOUNCE_CYCLES+1). Counter clears whenever the synced input equals btn_level.
//    Otherwise the counter increments. On reaching DEBOUNCE_CYCLES, btn_level flips and the counter clears.
//    A glitch shorter than DEBOUNCE_CYCLES never changes btn_level.
//  - Edge: press = one-cycle pulse on a 0->1 transition of btn_level. Releases produce no event.
//  - Fire repeat FSM (advances only on frame_tick):
//    IDLE --fire press--> DELAY (cnt=0).
//    DELAY: on frame_tick cnt++. When cnt reaches REPEAT_DELAY_FRAMES, emit a repeat fire, go to REPEAT (cnt=0).
//    REPEAT: on frame_tick cnt++. When cnt reaches REPEAT_RATE_FRAMES, emit a repeat fire and reset cnt.
//    Any state goes to IDLE when btn_level[d]=0; release has priority over the repeat emit in the same cycle.
//  - Accumulators: fire_acc is set by a fire press or repeat emit; pause_acc is set by a btn_u press.
//    Both are sticky until captured, so a press between ticks is never lost.
//  - Capture on frame_tick when !cmd_valid:
//    move_l = btn_level[l] & ~btn_level[r]; move_r = btn_level[r] & ~btn_level[l] (both held -> both 0).
//    fire = fire_acc | (event this cycle); pause likewise. cmd_valid<=1 next cycle; accumulators clear
//    except for an event arriving in the capture cycle itself, which is included in cmd and not re-accumulated.
//  - Handshake: cmd is stable while cmd_valid && !cmd_ready. On accept, cmd_valid<=0 next cycle.
//  - frame_tick while a command is still pending (not accepted): moves are overwritten with the current levels.
//    fire/pause are OR-merged into the pending word; cmd_valid stays 1.
//  - frame_tick in the same cycle as accept: the accept completes and a fresh capture loads, so cmd_valid stays 1 with new contents.
//  - Reset mid-operation (rst_n low at any point): immediate return to reset values; no command is emitted on release of reset.
// STRUCTURE
//  - Package chipinvaders_pkg: typedef struct packed {pause,fire,move_r,move_l} game_cmd_t;
//    typedef enum {RPT_IDLE,RPT_DELAY,RPT_REPEAT} fire_rpt_e; button index localparams BTN_L=0, BTN_R=1, BTN_D=2, BTN_U=3.
//  - One sub-module, btn_debounce (sync + debounce + press pulse, parameter DEBOUNCE_CYCLES), instantiated x4.
//  - Repeat FSM, accumulators and the handshake register live in input_controller.
// TESTING (bench params DEBOUNCE_CYCLES=4, REPEAT_DELAY_FRAMES=3, REPEAT_RATE_FRAMES=2)
//  1. btn_l high for 3 cycles, then low -> btn_level stays 0; no cmd changes.
//  2. btn_l held; frame_tick; cmd_ready=1 -> cmd=4'b0001, cmd_valid for one cycle.
//     Also hold btn_r -> cmd=4'b0000 on the next frame.
//  3. btn_d pressed once between ticks, cmd_ready=1 -> exactly one cmd with fire=1.
//     The following frame gives fire=0.
//  4. btn_d held across 9 frame_ticks -> fire=1 on frames 1, 4, 6, 8 (press, delay 3, rate 2).
//     After release, no further fire.
//  5. cmd_ready=0; pause press, then a second frame_tick with btn_l held -> cmd_valid stays 1; cmd=4'b1001 held.
//     Raise cmd_ready -> one accept; cmd_valid drops.
//  6. Assert rst_n=0 mid-DELAY with cmd pending -> cmd_valid=0, cmd=0, btn_level=0 immediately.
//     With btn_d still held after reset, the first fire appears only after debounce plus a frame_tick.

Source files
------------

// File: rtl/chipinvaders_pkg.sv
// Shared types and button indices for the chipinvaders input path.
package chipinvaders_pkg;

  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned BTN_L   = 0;
  localparam int unsigned BTN_R   = 1;
  localparam int unsigned BTN_D   = 2;
  localparam int unsigned BTN_U   = 3;

  typedef struct packed {
    logic pause;
    logic fire;
    logic move_r;
    logic move_l;
  } game_cmd_t;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } fire_rpt_e;

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-flop synchroniser, stable-count debouncer, press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
    end
  end

  // Level flips after DEBOUNCE_CYCLES consecutive disagreeing samples; press rides the 0->1 flip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync_2;
        press <= sync_2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/input_controller.sv
// Turns debounced buttons into one game command per frame, with fire auto-repeat.
module input_controller
  import chipinvaders_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = 250000,
  parameter int unsigned REPEAT_DELAY_FRAMES = 20,
  parameter int unsigned REPEAT_RATE_FRAMES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_d,
  input  logic       btn_u,
  input  logic       frame_tick,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [3:0] cmd,
  output logic [3:0] btn_level
);

  localparam int unsigned RPT_MAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                                    REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
  localparam int unsigned RW      = $clog2(RPT_MAX + 1);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] lvl;
  logic [NUM_BTN-1:0] press;

  fire_rpt_e rpt_state, rpt_nxt;
  logic [RW-1:0] rpt_cnt, cnt_nxt, cnt_inc;
  logic          rpt_fire_c;

  game_cmd_t cmd_q;
  logic      fire_acc, pause_acc;
  logic      fire_evt_c, pause_evt_c;
  logic      move_l_c, move_r_c;

  assign btn_raw = {btn_u, btn_d, btn_r, btn_l};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_raw[i]),
      .level(lvl[i]),
      .press(press[i])
    );
  end

  assign btn_level = lvl;
  assign cmd       = cmd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_state <= RPT_IDLE;
      rpt_cnt   <= '0;
    end else begin
      rpt_state <= rpt_nxt;
      rpt_cnt   <= cnt_nxt;
    end
  end

  assign cnt_inc = rpt_cnt + RW'(1);

  // Release of fire wins over any repeat emit due in the same cycle.
  always_comb begin
    rpt_nxt    = rpt_state;
    cnt_nxt    = rpt_cnt;
    rpt_fire_c = 1'b0;
    if (!lvl[BTN_D]) begin
      rpt_nxt = RPT_IDLE;
      cnt_nxt = '0;
    end else begin
      case (rpt_state)
        RPT_IDLE: begin
          if (press[BTN_D]) begin
            rpt_nxt = RPT_DELAY;
            cnt_nxt = '0;
          end
        end
        RPT_DELAY: begin
          if (frame_tick) begin
            if (cnt_inc == RW'(REPEAT_DELAY_FRAMES)) begin
              rpt_fire_c = 1'b1;
              rpt_nxt    = RPT_REPEAT;
              cnt_nxt    = '0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end
        end
        RPT_REPEAT: begin
          if (frame_tick) begin
            if (cnt_inc == RW'(REPEAT_RATE_FRAMES)) begin
              rpt_fire_c = 1'b1;
              cnt_nxt    = '0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end
        end
        default: begin
          rpt_nxt = RPT_IDLE;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  assign fire_evt_c  = press[BTN_D] | rpt_fire_c;
  assign pause_evt_c = press[BTN_U];
  assign move_l_c    = lvl[BTN_L] & ~lvl[BTN_R];
  assign move_r_c    = lvl[BTN_R] & ~lvl[BTN_L];

  // Fresh load when the slot is free or being accepted; otherwise merge into the pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q     <= '0;
      cmd_valid <= 1'b0;
      fire_acc  <= 1'b0;
      pause_acc <= 1'b0;
    end else if (frame_tick && (!cmd_valid || cmd_ready)) begin
      cmd_q.move_l <= move_l_c;
      cmd_q.move_r <= move_r_c;
      cmd_q.fire   <= fire_acc | fire_evt_c;
      cmd_q.pause  <= pause_acc | pause_evt_c;
      cmd_valid    <= 1'b1;
      fire_acc     <= 1'b0;
      pause_acc    <= 1'b0;
    end else if (frame_tick) begin
      cmd_q.move_l <= move_l_c;
      cmd_q.move_r <= move_r_c;
      cmd_q.fire   <= cmd_q.fire | fire_acc | fire_evt_c;
      cmd_q.pause  <= cmd_q.pause | pause_acc | pause_evt_c;
      fire_acc     <= 1'b0;
      pause_acc    <= 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
      fire_acc  <= fire_acc | fire_evt_c;
      pause_acc <= pause_acc | pause_evt_c;
    end
  end

endmodule

// File: tb/tb_input_controller.sv
// Directed bench for input_controller with short debounce and repeat timing.
module tb_input_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_l, btn_r, btn_d, btn_u;
  logic       frame_tick;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd;
  logic [3:0] btn_level;

  int n_checks = 0;
  int n_pass   = 0;

  input_controller #(
    .DEBOUNCE_CYCLES    (4),
    .REPEAT_DELAY_FRAMES(3),
    .REPEAT_RATE_FRAMES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_l     (btn_l),
    .btn_r     (btn_r),
    .btn_d     (btn_d),
    .btn_u     (btn_u),
    .frame_tick(frame_tick),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle frame_tick; returns at the negedge after the capturing posedge.
  task automatic frame();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_lvl(input int idx, input logic val, input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (btn_level[idx] === val) break;
    end
    chk(tag, {3'b000, btn_level[idx]}, {3'b000, val});
  endtask

  logic [9:0] fire_exp;

  initial begin
    rst_n = 1'b0; btn_l = 0; btn_r = 0; btn_d = 0; btn_u = 0;
    frame_tick = 0; cmd_ready = 0;
    cyc(2);
    chk("rst_valid", {3'b0, cmd_valid}, 4'd0);
    chk("rst_cmd", cmd, 4'd0);
    chk("rst_level", btn_level, 4'd0);
    rst_n = 1'b1;
    cyc(2);

    // 1: 3-cycle glitch is filtered
    btn_l = 1; cyc(3); btn_l = 0; cyc(8);
    chk("glitch_level", btn_level, 4'd0);
    chk("glitch_valid", {3'b0, cmd_valid}, 4'd0);

    // 2: exact debounce latency, move left, then both held
    cmd_ready = 1;
    btn_l = 1; cyc(5);
    chk("deb_early", btn_level, 4'b0000);
    cyc(1);
    chk("deb_flip", btn_level, 4'b0001);
    frame();
    chk("left_valid", {3'b0, cmd_valid}, 4'd1);
    chk("left_cmd", cmd, 4'b0001);
    cyc(1);
    chk("left_accept", {3'b0, cmd_valid}, 4'd0);
    btn_r = 1; wait_lvl(1, 1'b1, "r_level");
    frame();
    chk("both_cmd", cmd, 4'b0000);
    chk("both_valid", {3'b0, cmd_valid}, 4'd1);
    btn_l = 0; btn_r = 0; cyc(8);

    // 3: single fire press between ticks
    btn_d = 1; wait_lvl(2, 1'b1, "d_level");
    btn_d = 0; wait_lvl(2, 1'b0, "d_release");
    cyc(2);
    frame();
    chk("fire_once", cmd, 4'b0100);
    cyc(2);
    frame();
    chk("fire_after", cmd, 4'b0000);
    cyc(2);

    // 4: held fire, press coincides with frame 1 -> fires on frames 1,4,6,8
    fire_exp = 10'b0010101001;
    btn_d = 1; wait_lvl(2, 1'b1, "d_hold_level");
    for (int f = 0; f < 9; f++) begin
      frame();
      chk($sformatf("rpt_frame%0d", f + 1), cmd, {1'b0, fire_exp[f], 2'b00});
      cyc(2);
    end
    btn_d = 0; cyc(8);
    frame();
    chk("rpt_released", cmd, 4'b0000);
    cyc(2);

    // 5: pending command merges pause and keeps move
    cmd_ready = 0;
    btn_l = 1; wait_lvl(0, 1'b1, "l_level5");
    btn_u = 1; wait_lvl(3, 1'b1, "u_level5");
    cyc(2);
    frame();
    chk("pause_cmd", cmd, 4'b1001);
    cyc(3);
    frame();
    chk("pend_valid", {3'b0, cmd_valid}, 4'd1);
    chk("pend_cmd", cmd, 4'b1001);
    cmd_ready = 1; cyc(1);
    chk("pend_accept", {3'b0, cmd_valid}, 4'd0);
    btn_u = 0; btn_l = 0; cyc(8);

    // tick in the same cycle as accept reloads the slot
    cmd_ready = 0;
    btn_r = 1; wait_lvl(1, 1'b1, "r_level6");
    frame();
    chk("right_cmd", cmd, 4'b0010);
    btn_r = 0; wait_lvl(1, 1'b0, "r_release6");
    cmd_ready = 1;
    frame();
    chk("reload_valid", {3'b0, cmd_valid}, 4'd1);
    chk("reload_cmd", cmd, 4'b0000);
    cyc(1);
    chk("reload_accept", {3'b0, cmd_valid}, 4'd0);

    // 6: reset mid-DELAY with a pending command
    cmd_ready = 0;
    btn_d = 1; wait_lvl(2, 1'b1, "d_level7");
    cyc(1);
    frame();
    chk("pre_rst_cmd", cmd, 4'b0100);
    cyc(1);
    rst_n = 0;
    #1;
    chk("midrst_valid", {3'b0, cmd_valid}, 4'd0);
    chk("midrst_cmd", cmd, 4'd0);
    chk("midrst_level", btn_level, 4'd0);
    @(negedge clk);
    rst_n = 1; cmd_ready = 1;
    cyc(1);
    chk("postrst_valid", {3'b0, cmd_valid}, 4'd0);
    wait_lvl(2, 1'b1, "postrst_d_level");
    chk("postrst_idle", {3'b0, cmd_valid}, 4'd0);
    cyc(1);
    frame();
    chk("postrst_fire", cmd, 4'b0100);
    chk("postrst_fvalid", {3'b0, cmd_valid}, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
